arbiter_wrr: RTL and testbench
==============================

// Module: arbiter_wrr
// PURPOSE
//  Parametrised weighted round-robin arbiter with a per-port burst quota and a hold timeout.
//  A granted port keeps ownership until it pulses release.
//  On release it is re-granted back-to-back while it has quota left; otherwise the grant
//  rotates to the next requester. Muxes multi-beat AXIS/packet sources onto one shared sink.
// PARAMETERS
//  PORTS          4   number of requesters, >=2
//  WEIGHT_W       4   width of each per-port weight (grants per turn); weight 0 disables port
//  LSB_HIGH_PRIO  1   1: lowest index wins ties and rotation ascends; 0: highest index, descends
//  HOLD_TIMEOUT   0   cycles a grant may be held without release; 0 disables timeout
// PORTS
//  clk            in   1                  clock, all logic on rising edge
//  rst_n          in   1                  asynchronous active-low reset
//  request        in   PORTS              level request per port
//  release        in   PORTS              1-cycle pulse: granted port finished one transfer
//  weight         in   PORTS*WEIGHT_W     port i quota = weight[i*WEIGHT_W +: WEIGHT_W]
//  grant          out  PORTS              one-hot grant, registered
//  grant_valid    out  1                  grant holds a port
//  grant_encoded  out  $clog2(PORTS)      index of granted port
//  timeout        out  1                  1-cycle pulse: grant revoked by timeout
// BEHAVIOUR
//  Reset: async assert, sync deassert. Reset values:
//   - grant, grant_valid, grant_encoded, timeout, credit, hold counter = 0
//   - rotation mask = 0, so the first pick is plain priority
//  Eligible set: elig = request & (weight != 0).
//  Arbitration runs when grant_valid=0, or when release of the granted port is seen.
//  Winner is registered, so latency is 1 cycle from request to grant. A winner picked in a
//  release cycle gives a gapless handover: grant_valid stays 1.
//  Winner selection, in order:
//   (a) Re-grant: granted port still in elig and credit != 0 -> keep same port, credit--.
//   (b) Rotate: masked pick over elig & mask; if empty, unmasked pick over elig.
//       Load credit = weight[winner]-1. Mask = ports strictly after winner in rotation order.
//   (c) Nothing eligible: grant_valid=0, grant=0, grant_encoded=0; mask and credit hold.
//  Release bits of non-granted ports are ignored. Release when grant_valid=0 is ignored.
//  Request drop while granted: ownership is kept until release or timeout.
//  Weight is sampled only when credit is loaded. Mid-grant weight changes take effect at the
//  next load.
//  Timeout (HOLD_TIMEOUT>0):
//   - hold counter clears on each new grant and on each release; otherwise increments while
//     grant_valid=1.
//   - reaching HOLD_TIMEOUT-1 without release: pulse timeout, run arbitration as in (b) with
//     the offender excluded this cycle, zero credit.
//   - if the offender is the only eligible port, grant_valid drops for at least 1 cycle.
//  Simultaneous release and timeout in the same cycle: release wins, no timeout pulse.
//  Width rules:
//   - credit is WEIGHT_W bits, decrement never wraps (guarded by credit != 0).
//   - hold counter is $clog2(HOLD_TIMEOUT+1) bits, saturating.
//  Reset mid-grant: all outputs go to 0 at once. No release is expected afterwards.
// STRUCTURE
//  Package arb_pkg:
//   - arb_state_e {ARB_IDLE, ARB_GRANTED}
//   - function rr_mask(idx, lsb_high) returning the mask after a winner
//   - function onehot(idx)
//  Sub-module priority_encoder (WIDTH=PORTS, LSB_HIGH_PRIORITY), two instances: masked and
//  unmasked.
//  Top contains the 2-state FSM, credit counter, hold counter, mask register and output
//  registers only.
// TESTING
//  1. PORTS=4, weights all 1, request=4'b1111, release every cycle
//     -> grant_encoded 0,1,2,3,0,..., grant_valid continuously 1.
//  2. weight={1,1,1,3} (port0=3), request=4'b0011, release every 2nd cycle
//     -> grants 0,0,0,1,0,0,0,1; credit reload seen on each port0 regrant-after-rotation.
//  3. weight[2]=0, request=4'b0100 -> grant_valid stays 0.
//     Then set weight[2]=2 -> grant=4'b0100 one cycle later.
//  4. HOLD_TIMEOUT=8, port1 granted and never releases, request=4'b0011
//     -> timeout pulses on cycle 8 of hold, next grant=port0. Same with only port1 requesting
//     -> grant_valid drops to 0 for 1 cycle, then port1 is regranted.
//  5. rst_n asserted mid-grant (async, between edges) -> grant=0, grant_valid=0 immediately.
//     After deassert, request=4'b1000 -> grant_encoded=3 after 1 cycle.
//  6. LSB_HIGH_PRIO=0, weights 1, request=4'b1111 -> order 3,2,1,0.
//     Release asserted on a non-granted port -> no grant change.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the weighted round-robin arbiter
package arb_pkg;

    localparam int MAX_PORTS = 32;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANTED
    } arb_state_e;

    function automatic logic [MAX_PORTS-1:0] onehot(input int unsigned idx);
        return MAX_PORTS'(1) << idx;
    endfunction

    // Ports strictly after idx in rotation order: above idx when ascending, below when descending.
    function automatic logic [MAX_PORTS-1:0] rr_mask(input int unsigned idx, input bit lsb_high);
        logic [MAX_PORTS-1:0] below;
        below = onehot(idx) - MAX_PORTS'(1);
        if (lsb_high) begin
            return ~(below | onehot(idx));
        end
        return below;
    endfunction

endpackage

// File: rtl/arbiter_wrr_if.sv
// rtl/arbiter_wrr_if.sv - request/grant bundle between requesters and the arbiter
// request        requester -> arbiter  level request per port
// release_pulse  requester -> arbiter  1-cycle pulse, granted port finished one transfer
// weight         requester -> arbiter  per-port quota, WEIGHT_W bits each
// grant          arbiter -> requester  one-hot grant
// grant_valid    arbiter -> requester  grant holds a port
// grant_encoded  arbiter -> requester  index of granted port
// timeout        arbiter -> requester  1-cycle pulse, grant revoked by hold timeout
interface arbiter_wrr_if #(
    parameter int PORTS    = 4,
    parameter int WEIGHT_W = 4
);
    logic [PORTS-1:0]          request;
    logic [PORTS-1:0]          release_pulse;
    logic [PORTS*WEIGHT_W-1:0] weight;
    logic [PORTS-1:0]          grant;
    logic                      grant_valid;
    logic [$clog2(PORTS)-1:0]  grant_encoded;
    logic                      timeout;

    modport master (
        output request, release_pulse, weight,
        input  grant, grant_valid, grant_encoded, timeout
    );

    modport slave (
        input  request, release_pulse, weight,
        output grant, grant_valid, grant_encoded, timeout
    );
endinterface

// File: rtl/priority_encoder.sv
// rtl/priority_encoder.sv - fixed-priority pick of one set bit
// req    in   WIDTH           candidate vector
// valid  out  1               at least one bit set
// idx    out  $clog2(WIDTH)   winning index (lowest if LSB_HIGH_PRIORITY, else highest)
module priority_encoder #(
    parameter int WIDTH             = 4,
    parameter bit LSB_HIGH_PRIORITY = 1'b1
) (
    input  logic [WIDTH-1:0]         req,
    output logic                     valid,
    output logic [$clog2(WIDTH)-1:0] idx
);
    localparam int IDX_W = $clog2(WIDTH);

    // Scan from the low-priority end; the last hit is the winner.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        if (LSB_HIGH_PRIORITY) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (req[i]) begin
                    valid = 1'b1;
                    idx   = IDX_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (req[i]) begin
                    valid = 1'b1;
                    idx   = IDX_W'(i);
                end
            end
        end
    end
endmodule

// File: rtl/arbiter_wrr.sv
// rtl/arbiter_wrr.sv - weighted round-robin arbiter with burst quota and hold timeout
// clk    in     rising-edge clock
// rst_n  in     asynchronous active-low reset
// bus    slave  request/release/weight in, grant/grant_valid/grant_encoded/timeout out
module arbiter_wrr
    import arb_pkg::*;
#(
    parameter int PORTS         = 4,
    parameter int WEIGHT_W      = 4,
    parameter bit LSB_HIGH_PRIO = 1'b1,
    parameter int HOLD_TIMEOUT  = 0
) (
    input logic         clk,
    input logic         rst_n,
    arbiter_wrr_if.slave bus
);
    localparam int IDX_W  = $clog2(PORTS);
    localparam int HOLD_W = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
    logic [PORTS-1:0]  grant_q, grant_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [PORTS-1:0]  mask_q, mask_d;
    logic              timeout_q, timeout_d;

    logic [WEIGHT_W-1:0] w_arr [PORTS];
    logic [PORTS-1:0]  elig, cand;
    logic              rel_hit, to_hit;
    logic              m_valid, u_valid;
    logic [IDX_W-1:0]  m_idx, u_idx, win_idx;

    for (genvar i = 0; i < PORTS; i++) begin : g_port
        assign w_arr[i] = bus.weight[i*WEIGHT_W +: WEIGHT_W];
        assign elig[i]  = bus.request[i] && (w_arr[i] != '0);
    end

    assign rel_hit = (state_q == ARB_GRANTED) && bus.release_pulse[grant_idx_q];
    // A release in the same cycle always pre-empts the timeout.
    assign to_hit  = (HOLD_TIMEOUT > 0) && (state_q == ARB_GRANTED) && !rel_hit
                     && (hold_q == HOLD_LAST);

    // The timed-out owner sits out the arbitration that revokes it.
    always_comb begin
        cand = elig;
        if (to_hit) begin
            cand[grant_idx_q] = 1'b0;
        end
    end

    priority_encoder #(.WIDTH(PORTS), .LSB_HIGH_PRIORITY(LSB_HIGH_PRIO)) u_pe_masked (
        .req   (cand & mask_q),
        .valid (m_valid),
        .idx   (m_idx)
    );

    priority_encoder #(.WIDTH(PORTS), .LSB_HIGH_PRIORITY(LSB_HIGH_PRIO)) u_pe_plain (
        .req   (cand),
        .valid (u_valid),
        .idx   (u_idx)
    );

    assign win_idx = m_valid ? m_idx : u_idx;

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        credit_d    = credit_q;
        hold_d      = hold_q;
        mask_d      = mask_q;
        timeout_d   = 1'b0;

        if ((state_q == ARB_IDLE) || rel_hit || to_hit) begin
            hold_d    = '0;
            timeout_d = to_hit;
            if (rel_hit && elig[grant_idx_q] && (credit_q != '0)) begin
                credit_d = credit_q - WEIGHT_W'(1);
            end else if (u_valid) begin
                state_d     = ARB_GRANTED;
                grant_idx_d = win_idx;
                credit_d    = w_arr[win_idx] - WEIGHT_W'(1);
                mask_d      = PORTS'(rr_mask(32'(win_idx), LSB_HIGH_PRIO));
            end else begin
                state_d     = ARB_IDLE;
                grant_idx_d = '0;
                if (to_hit) begin
                    credit_d = '0;
                end
            end
        end else if (hold_q != '1) begin
            hold_d = hold_q + HOLD_W'(1);
        end

        grant_d = (state_d == ARB_GRANTED) ? PORTS'(onehot(32'(grant_idx_d))) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            grant_idx_q <= '0;
            grant_q     <= '0;
            credit_q    <= '0;
            hold_q      <= '0;
            mask_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            grant_q     <= grant_d;
            credit_q    <= credit_d;
            hold_q      <= hold_d;
            mask_q      <= mask_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.grant_valid   = (state_q == ARB_GRANTED);
    assign bus.grant_encoded = grant_idx_q;
    assign bus.timeout       = timeout_q;
endmodule

// File: tb/tb_arbiter_wrr.sv
// tb/tb_arbiter_wrr.sv - self-checking bench for arbiter_wrr against a behavioural model
module tb_arbiter_wrr;

    localparam bit [15:0] W1 = 16'h1111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arbiter_wrr_if #(.PORTS(4), .WEIGHT_W(4)) ifa ();
    arbiter_wrr_if #(.PORTS(4), .WEIGHT_W(4)) ifb ();

    arbiter_wrr #(.PORTS(4), .WEIGHT_W(4), .LSB_HIGH_PRIO(1'b1), .HOLD_TIMEOUT(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    arbiter_wrr #(.PORTS(4), .WEIGHT_W(4), .LSB_HIGH_PRIO(1'b0), .HOLD_TIMEOUT(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    typedef struct packed {
        bit valid;
        int idx;
        int credit;
        int hold;
        int last;
        bit to;
    } mdl_t;

    mdl_t ma, mb;
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_init(input bit lsb);
        mdl_t m;
        m.valid  = 1'b0;
        m.idx    = 0;
        m.credit = 0;
        m.hold   = 0;
        m.to     = 1'b0;
        m.last   = lsb ? -1 : 4;
        return m;
    endfunction

    // Next owner after one clock, given the inputs of that cycle.
    function automatic mdl_t mdl_step(input mdl_t m, input bit [3:0] req, input bit [3:0] rel,
                                      input bit [15:0] w, input int ht, input bit lsb);
        mdl_t n;
        bit [3:0] elig;
        bit rel_hit, to_hit, found;
        int q, p;
        n = m;
        for (int i = 0; i < 4; i++) elig[i] = req[i] && (w[i*4 +: 4] != 4'd0);
        rel_hit = m.valid && rel[m.idx];
        to_hit  = (ht > 0) && m.valid && !rel_hit && (m.hold >= ht - 1);
        n.to = to_hit;
        if (m.valid && !rel_hit && !to_hit) begin
            n.hold = m.hold + 1;
            return n;
        end
        n.hold = 0;
        if (rel_hit && elig[m.idx] && m.credit > 0) begin
            n.credit = m.credit - 1;
            return n;
        end
        found = 1'b0;
        for (int k = 1; k <= 4 && !found; k++) begin
            q = lsb ? m.last + k : m.last - k;
            p = ((q % 4) + 4) % 4;
            if (elig[p] && !(to_hit && p == m.idx)) begin
                found    = 1'b1;
                n.valid  = 1'b1;
                n.idx    = p;
                n.credit = int'(w[p*4 +: 4]) - 1;
                n.last   = p;
            end
        end
        if (!found) begin
            n.valid = 1'b0;
            n.idx   = 0;
            if (to_hit) n.credit = 0;
        end
        return n;
    endfunction

    task automatic check_all();
        check("a_valid", 32'(ifa.grant_valid), 32'(ma.valid));
        check("a_grant", 32'(ifa.grant), ma.valid ? (32'(1) << ma.idx) : 32'(0));
        check("a_enc", 32'(ifa.grant_encoded), 32'(ma.idx));
        check("a_timeout", 32'(ifa.timeout), 32'(ma.to));
        check("b_valid", 32'(ifb.grant_valid), 32'(mb.valid));
        check("b_grant", 32'(ifb.grant), mb.valid ? (32'(1) << mb.idx) : 32'(0));
        check("b_enc", 32'(ifb.grant_encoded), 32'(mb.idx));
        check("b_timeout", 32'(ifb.timeout), 32'(mb.to));
    endtask

    // Called at a falling edge: check, drive the next inputs, advance both models.
    task automatic cyc(input bit [3:0] rq, input bit [3:0] rl_a, input bit [3:0] rl_b,
                       input bit [15:0] wa, input bit [15:0] wb);
        check_all();
        ifa.request = rq; ifa.release_pulse = rl_a; ifa.weight = wa;
        ifb.request = rq; ifb.release_pulse = rl_b; ifb.weight = wb;
        ma = mdl_step(ma, rq, rl_a, wa, 8, 1'b1);
        mb = mdl_step(mb, rq, rl_b, wb, 0, 1'b0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_a_valid", 32'(ifa.grant_valid), 32'(0));
        check("rst_a_grant", 32'(ifa.grant), 32'(0));
        check("rst_a_enc", 32'(ifa.grant_encoded), 32'(0));
        check("rst_b_valid", 32'(ifb.grant_valid), 32'(0));
        check("rst_b_grant", 32'(ifb.grant), 32'(0));
        ifa.request = '0; ifa.release_pulse = '0; ifa.weight = W1;
        ifb.request = '0; ifb.release_pulse = '0; ifb.weight = W1;
        ma = mdl_init(1'b1);
        mb = mdl_init(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic timeout_run(input bit [3:0] rq, output bit seen, output int held);
        seen = 1'b0;
        held = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            if (ifa.timeout) begin
                seen = 1'b1;
            end else begin
                if (ifa.grant_valid && ifa.grant_encoded == 2'd1) held++;
                cyc(rq, 4'h0, 4'h0, W1, W1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bit seen;
        int held;
        bit [15:0] wa, wb;
        bit [3:0] rq, ga, gb, rla, rlb;

        ifa.request = '0; ifa.release_pulse = '0; ifa.weight = W1;
        ifb.request = '0; ifb.release_pulse = '0; ifb.weight = W1;
        ma = mdl_init(1'b1);
        mb = mdl_init(1'b0);
        @(negedge clk);
        do_reset();

        // plain rotation, ascending on a and descending on b
        cyc(4'hF, 4'h0, 4'h0, W1, W1);
        for (int k = 0; k < 8; k++) begin
            check("t1_enc", 32'(ifa.grant_encoded), 32'(k % 4));
            check("t1_valid", 32'(ifa.grant_valid), 32'(1));
            check("t6_enc", 32'(ifb.grant_encoded), 32'(3 - k % 4));
            cyc(4'hF, 4'hF, 4'hF, W1, W1);
        end
        // releases from non-granted ports must not move b off port 3
        for (int k = 0; k < 4; k++) begin
            check("t6_hold", 32'(ifb.grant_encoded), 32'(3));
            cyc(4'hF, 4'h0, 4'b0111, W1, W1);
        end

        // port0 quota 3 vs port1 quota 1
        do_reset();
        for (int k = 0; k <= 16; k++) begin
            bit [3:0] rl;
            rl = (k >= 2 && k % 2 == 0) ? 4'hF : 4'h0;
            if (k >= 2 && k % 2 == 0)
                check("t2_enc", 32'(ifa.grant_encoded), (((k - 2) / 2) % 4 == 3) ? 32'(1) : 32'(0));
            cyc(4'h3, rl, rl, 16'h1113, 16'h1113);
        end

        // zero weight disables a port
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(4'h4, 4'h0, 4'h0, 16'h1011, 16'h1011);
            check("t3_idle", 32'(ifa.grant_valid), 32'(0));
        end
        cyc(4'h4, 4'h0, 4'h0, 16'h1211, 16'h1211);
        check("t3_grant", 32'(ifa.grant), 32'(4'b0100));

        // hold timeout with an alternative requester
        do_reset();
        cyc(4'h2, 4'h0, 4'h0, W1, W1);
        timeout_run(4'h3, seen, held);
        check("t4_seen", 32'(seen), 32'(1));
        check("t4_held", 32'(held), 32'(8));
        check("t4_next", 32'(ifa.grant_encoded), 32'(0));
        check("t4_nvalid", 32'(ifa.grant_valid), 32'(1));

        // hold timeout with the offender alone
        do_reset();
        cyc(4'h2, 4'h0, 4'h0, W1, W1);
        timeout_run(4'h2, seen, held);
        check("t4b_seen", 32'(seen), 32'(1));
        check("t4b_held", 32'(held), 32'(8));
        check("t4b_drop", 32'(ifa.grant_valid), 32'(0));
        cyc(4'h2, 4'h0, 4'h0, W1, W1);
        check("t4b_regrant", 32'(ifa.grant_valid), 32'(1));
        check("t4b_enc", 32'(ifa.grant_encoded), 32'(1));

        // reset in the middle of a grant, then a fresh request
        do_reset();
        cyc(4'hF, 4'h0, 4'h0, W1, W1);
        check("t5_pre", 32'(ifa.grant_valid), 32'(1));
        do_reset();
        cyc(4'h8, 4'h0, 4'h0, W1, W1);
        check("t5_enc", 32'(ifa.grant_encoded), 32'(3));
        check("t5_valid", 32'(ifa.grant_valid), 32'(1));

        // randomized traffic against the model
        do_reset();
        wa = W1;
        wb = W1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                wa = 16'($urandom);
                wb = 16'($urandom);
            end
            rq  = 4'($urandom);
            ga  = ma.valid ? 4'(1 << ma.idx) : 4'h0;
            gb  = mb.valid ? 4'(1 << mb.idx) : 4'h0;
            rla = (($urandom_range(0, 2) == 0) ? ga : 4'h0) | (4'($urandom) & ~ga);
            rlb = (($urandom_range(0, 2) == 0) ? gb : 4'h0) | (4'($urandom) & ~gb);
            cyc(rq, rla, rlb, wa, wb);
        end
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
